volume_envelope: RTL
====================

Name: volume_envelope

Overview:
- Downstream amplitude stage for the noise channel. Consumes the channel's 1-bit gated noise output and produces a 4-bit unsigned amplitude sample for the mixer.
- Implements the NR42 volume envelope:
  - starting volume;
  - add/subtract mode;
  - period in envelope ticks.
- Driven by the 64 Hz envelope strobe from the frame sequencer.
- Replaces the channel's missing volume control. Reusable by the square channels.

Parameters:
- VOL_W, 4, width of volume register and output sample.
- PERIOD_W, 3, width of envelope period field.

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  synchronous, active-high reset.
- envTick  in  1  one-clk-wide 64 Hz envelope strobe, synchronous to clk.
- trigger  in  1  one-clk-wide channel trigger strobe (NR44 bit 7).
- startVol  in  VOL_W  NR42 starting volume.
- envAdd  in  1  NR42 direction: 1 = increase, 0 = decrease.
- envPeriod  in  PERIOD_W  NR42 period; 0 = envelope frozen.
- noiseIn  in  1  gated noise bit from the noise channel (already includes length enable).
- sample  out  VOL_W  registered amplitude: volume when noiseIn is high, else 0.
- volume  out  VOL_W  current envelope volume, registered.

Behaviour:
- All state updates on posedge clk. rst has priority over every other input.
- Reset values:
  - volume = 0, sample = 0;
  - internal counter = 0, running = 0;
  - latched add = 0, latched period = 0.
- Trigger (highest priority after rst):
  - volume <= startVol;
  - latched add <= envAdd, latched period <= envPeriod;
  - counter <= envPeriod;
  - running <= 1.
  - Later NR42 input changes are ignored until the next trigger.
- envTick with no trigger, running = 1 and latched period != 0:
  - If counter > 1: counter decrements.
  - If counter == 1: counter reloads the latched period, then one step is applied:
    - add = 1 and volume < 15: volume + 1;
    - add = 0 and volume > 0: volume - 1;
    - otherwise: volume unchanged and running <= 0 (envelope finished; no further steps until re-trigger).
- envTick with running = 0 or latched period = 0: no state change.
- trigger and envTick in the same cycle: trigger wins; the tick is discarded; counter = envPeriod.
- Volume saturates at 0 and 15 and never wraps.
- sample <= noiseIn ? volume_next : 0.
  - Latency: 1 clk from noiseIn, and 1 clk from trigger to new volume on sample.
- rst asserted mid-envelope: all state returns to reset values on that edge. The envelope stays idle until the next trigger.
- Internal states, encoded by running:
  - IDLE (running = 0) --trigger--> RUN;
  - RUN --saturating step--> IDLE;
  - RUN --trigger--> RUN (reload).

Optional Feature:
- Macro: VOLUME_ENVELOPE_DONE_EN.
- Defined:
  - adds output port envDone (1 bit), equal to the registered value of !running;
  - reset value 1;
  - goes low on the clk after trigger;
  - goes high on the clk after the saturating step.
- Undefined: port absent; no other behaviour changes.

Decomposition:
- Shared package (apu_pkg):
  - VOL_MAX = 15, VOL_W = 4, PERIOD_W = 3;
  - envelope direction constants ENV_DEC = 0, ENV_INC = 1.
- One sub-module, env_period_counter, containing:
  - the reloadable down-counter;
  - inputs load, loadVal, tick, enable;
  - output step, a one-clk pulse when counter == 1 on a tick.
- The top module holds the volume register, saturation logic, running flag and sample register.

Test Plan:
- rst then idle: sample = 0, volume = 0 for 100 clks, including envTick pulses; no steps before any trigger.
- trigger with startVol = 8, envAdd = 0, envPeriod = 2, noiseIn = 1:
  - volume = 8 next clk;
  - volume 7 after 2nd envTick, 6 after 4th;
  - after 16 ticks volume = 0 and stays 0; sample = 0.
- trigger with startVol = 13, envAdd = 1, envPeriod = 1: volume 14, then 15 on successive ticks; holds at 15; envDone = 1 after the step that would exceed 15 (with VOLUME_ENVELOPE_DONE_EN).
- envPeriod = 0, startVol = 5: 20 envTicks leave volume = 5; sample toggles between 5 and 0 following noiseIn with 1-clk latency.
- trigger and envTick in the same clk with counter == 1: no step occurs; counter = envPeriod; volume = startVol.
- rst asserted while volume = 9 in RUN: volume = 0 and sample = 0 next clk; subsequent ticks cause no change until re-trigger.

Source files
------------

// File: rtl/apu_pkg.sv
// Shared APU constants and the volume envelope state encoding.
package apu_pkg;

   localparam int VOL_W    = 4;
   localparam int PERIOD_W = 3;
   localparam int VOL_MAX  = 15;

   localparam logic ENV_DEC = 1'b0;
   localparam logic ENV_INC = 1'b1;

   // The envelope state is exactly the running flag.
   typedef enum logic {
      ENV_IDLE = 1'b0,
      ENV_RUN  = 1'b1
   } env_state_e;

endpackage

// File: rtl/env_period_counter.sv
// Reloadable envelope period down-counter; step pulses when a tick lands on count 1.
module env_period_counter #(
   parameter int PERIOD_W = 3
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [PERIOD_W-1:0] loadVal,
   input  logic                tick,
   input  logic                enable,
   output logic                step
);

   logic [PERIOD_W-1:0] count_r;
   logic [PERIOD_W-1:0] period_r;

   // A load on the same cycle as a tick swallows the tick.
   assign step = tick && enable && !load && (count_r == PERIOD_W'(1));

   // Count register with latched reload value; a zero period keeps the counter parked at 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         count_r  <= {PERIOD_W{1'b0}};
         period_r <= {PERIOD_W{1'b0}};
      end else if (load) begin
         count_r  <= loadVal;
         period_r <= loadVal;
      end else if (tick && enable && (count_r != {PERIOD_W{1'b0}})) begin
         if (step) begin
            count_r <= period_r;
         end else begin
            count_r <= count_r - PERIOD_W'(1);
         end
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/volume_envelope.sv
// Volume envelope and amplitude stage for the noise channel.
// Optional envDone output is enabled with VOLUME_ENVELOPE_DONE_EN.
module volume_envelope #(
   parameter int VOL_W    = apu_pkg::VOL_W,
   parameter int PERIOD_W = apu_pkg::PERIOD_W
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                envTick,
   input  logic                trigger,
   input  logic [VOL_W-1:0]    startVol,
   input  logic                envAdd,
   input  logic [PERIOD_W-1:0] envPeriod,
   input  logic                noiseIn,
   output logic [VOL_W-1:0]    sample,
   output logic [VOL_W-1:0]    volume
`ifdef VOLUME_ENVELOPE_DONE_EN
   ,
   output logic                envDone
`endif
);

   import apu_pkg::*;

   env_state_e       state_r, state_next_s;
   logic [VOL_W-1:0] volume_r, volume_next_s;
   logic [VOL_W-1:0] sample_r;
   logic             add_r, add_next_s;
   logic             step_s;

   env_period_counter #(
      .PERIOD_W (PERIOD_W)
   ) u_counter (
      .clk     (clk),
      .rst     (rst),
      .load    (trigger),
      .loadVal (envPeriod),
      .tick    (envTick),
      .enable  (state_r == ENV_RUN),
      .step    (step_s)
   );

   // Next state: trigger reloads everything, a step moves volume or ends the envelope at a rail.
   always_comb begin
      state_next_s  = state_r;
      volume_next_s = volume_r;
      add_next_s    = add_r;
      if (trigger) begin
         state_next_s  = ENV_RUN;
         volume_next_s = startVol;
         add_next_s    = envAdd;
      end else begin
         case (state_r)
            ENV_RUN: begin
               if (step_s) begin
                  if ((add_r == ENV_INC) && (volume_r < VOL_W'(VOL_MAX))) begin
                     volume_next_s = volume_r + VOL_W'(1);
                  end else if ((add_r == ENV_DEC) && (volume_r != {VOL_W{1'b0}})) begin
                     volume_next_s = volume_r - VOL_W'(1);
                  end else begin
                     state_next_s = ENV_IDLE;
                  end
               end else begin
                  state_next_s = ENV_RUN;
               end
            end
            default: begin
               state_next_s = ENV_IDLE;
            end
         endcase
      end
   end

   // State, volume and sample registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r  <= ENV_IDLE;
         volume_r <= {VOL_W{1'b0}};
         add_r    <= 1'b0;
         sample_r <= {VOL_W{1'b0}};
      end else begin
         state_r  <= state_next_s;
         volume_r <= volume_next_s;
         add_r    <= add_next_s;
         sample_r <= noiseIn ? volume_next_s : {VOL_W{1'b0}};
      end
   end

   assign volume = volume_r;
   assign sample = sample_r;

`ifdef VOLUME_ENVELOPE_DONE_EN
   logic done_r;

   // Registered idle indication, tracking the state register edge for edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         done_r <= 1'b1;
      end else begin
         done_r <= (state_next_s == ENV_IDLE);
      end
   end

   assign envDone = done_r;
`endif

endmodule
